md_controller: RTL
==================

# md_controller

Multi-cycle multiply/divide controller for the 5-stage pipeline's execute stage. It accepts one signed mult or div request from the decode/execute boundary and sequences an iterative shift-add / restoring-divide datapath over WIDTH cycles. It holds the pipeline stall line until writeback accepts the result. It owns the only multiplier/divider in the design; the ALU never sees mult/div opcodes.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration counter is $clog2(WIDTH)+1 bits
- REG_BITS, 5, destination register number width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the rising edge where it is high
- start_mult  in  1  request signed multiply of operand_a*operand_b
- start_div  in  1  request signed divide operand_a/operand_b
- operand_a  in  WIDTH  first operand, post-bypass
- operand_b  in  WIDTH  second operand, post-bypass
- dest_reg  in  REG_BITS  destination register, returned with result
- result_ack  in  1  writeback consumed result this cycle
- stall  out  1  freeze PC, F/D latch; insert noop into D/E
- busy  out  1  state != IDLE
- result_valid  out  1  result/result_reg/exception valid
- result  out  WIDTH  low WIDTH bits of product, or quotient
- result_reg  out  REG_BITS  latched dest_reg
- exception  out  1  mult overflow or divide-by-zero

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: start_mult or start_div latches operands, dest_reg, op; both high together → mult wins. Divide with operand_b==0 → DONE directly, result=0, exception=1. Otherwise load |a|, |b|, count=WIDTH-1, go BUSY.
- BUSY: one iteration per cycle (mult: conditional add + shift; div: shift, trial subtract, restore); count decrements; at count==0 go DONE, applying sign correction (negate if sign(a)^sign(b)).
- DONE: result_valid=1, outputs held stable. result_ack → IDLE. A start in the ack cycle is ignored; requester reissues next cycle.
- Starts in BUSY/DONE are ignored.
- Mult exception: full 2*WIDTH signed product not equal to sign-extension of its low WIDTH bits. Result still equals low WIDTH bits.
- Div: quotient truncates toward zero. MIN_INT/-1 → MIN_INT, exception=0. Remainder discarded.
- Arithmetic is unsigned on magnitudes; MIN_INT magnitude is representable as WIDTH-bit unsigned.

## Timing
- Reset values: stall=0, busy=0, result_valid=0, result=0, result_reg=0, exception=0, state=IDLE, count=0.
- stall = (IDLE & (start_mult|start_div)) | BUSY | (DONE & ~result_ack). This is combinational, so the start cycle already stalls.
- Latency: start sampled at edge 0; result_valid high from edge WIDTH+1 (33 cycles for WIDTH=32). Div-by-zero: result_valid from edge 1.
- result_valid stays high until the cycle result_ack is sampled; it drops on the following edge.
- Reset in any state aborts the operation. Outputs return to reset values on that edge; no result is produced.
- result_ack outside DONE is ignored.

## Configuration
- MD_DIVIDE_EN defined: divider path and div-by-zero detection are present as described.
- Not defined: divide hardware is removed. start_div (alone) goes IDLE→DONE in one cycle with result=0, exception=1. Multiply behaviour is unchanged.

## Structure
- Shared package md_pkg: state enum (IDLE/BUSY/DONE), op encoding (OP_MULT/OP_DIV), WIDTH default constant, mult/div ALU-opcode values used by decode.
- One sub-module, md_datapath, holds the accumulator/remainder, multiplicand/divisor and shift registers. Its control inputs are load, step and op; it outputs raw magnitude and overflow bit. Sign correction, FSM, counter and handshake stay in md_controller.

## Test plan
- Mult 7 * -3, ack held high → stall from start cycle; result_valid at cycle 33; result=0xFFFFFFEB, exception=0; idle next cycle.
- Div 100 / 7, ack delayed 3 cycles → result=14 held stable and stall high through the delay; drops after ack.
- Div 5 / 0 → result_valid at cycle 1, result=0, exception=1; without MD_DIVIDE_EN, same response for any divide.
- Mult 0x00010000 * 0x00010000 → result=0, exception=1; mult 0x80000000 / 0xFFFFFFFF (div) → 0x80000000, exception=0.
- Reset asserted at cycle 10 of a mult → next edge all outputs zero, state IDLE; a new mult issued afterward completes correctly.
- start_mult and start_div together, then new start pulses during BUSY → only the mult executes; extra starts ignored; result_reg equals the first dest_reg.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared states, op encoding and opcodes for the multiply/divide unit
package md_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_e;

    // ALU function codes that decode steers to this unit instead of the ALU
    localparam logic [5:0] ALU_FUNCT_MULT = 6'h18;
    localparam logic [5:0] ALU_FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/md_datapath.sv
// rtl/md_datapath.sv - shift-add multiplier / restoring divider on unsigned magnitudes; MD_DIVIDE_EN adds the divider
module md_datapath
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    input  logic             negative,
    output logic [WIDTH-1:0] magnitude,
    output logic             overflow
);

    // hi: product high half / partial remainder; lo: multiplier then product low half / dividend then quotient
    logic [WIDTH-1:0] hi, lo, operand;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH:0]   sum;
`ifdef MD_DIVIDE_EN
    logic [WIDTH:0]   shifted, trial;
`endif

    // One iteration of the selected algorithm
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
`ifdef MD_DIVIDE_EN
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, operand};
`endif
        if (op == OP_MULT) begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
`ifdef MD_DIVIDE_EN
        else if (!trial[WIDTH]) begin
            // partial remainder stays below the divisor, so bit WIDTH of trial is a clean borrow flag
            hi_next = trial[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_next = shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
        end
`endif
    end

    // Working registers: load operands, then iterate
    always_ff @(posedge clock) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            operand <= '0;
        end else if (load) begin
            hi      <= '0;
            lo      <= (op == OP_MULT) ? mag_b : mag_a;
            operand <= (op == OP_MULT) ? mag_a : mag_b;
        end else if (step) begin
            hi      <= hi_next;
            lo      <= lo_next;
        end
    end

    assign magnitude = lo;
    // A negative product may reach exactly 2^(WIDTH-1) in magnitude; a positive one may not
    assign overflow  = (|hi) | (lo[WIDTH-1] & (~negative | (|lo[WIDTH-2:0])));

endmodule

// File: rtl/md_controller.sv
// rtl/md_controller.sv - multi-cycle signed mult/div sequencer with pipeline stall; MD_DIVIDE_EN enables divide
module md_controller
    import md_pkg::*;
#(
    parameter int WIDTH    = MD_WIDTH,
    parameter int REG_BITS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_mult,
    input  logic                start_div,
    input  logic [WIDTH-1:0]    operand_a,
    input  logic [WIDTH-1:0]    operand_b,
    input  logic [REG_BITS-1:0] dest_reg,
    input  logic                result_ack,
    output logic                stall,
    output logic                busy,
    output logic                result_valid,
    output logic [WIDTH-1:0]    result,
    output logic [REG_BITS-1:0] result_reg,
    output logic                exception
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e        state, state_next;
    logic [CW-1:0]    count;
    md_op_e           op_q, dp_op;
    logic             neg_q, zero_q;
    logic             dp_load, dp_step, finish_zero, div_reject;
    logic [WIDTH-1:0] mag_a, mag_b, dp_mag;
    logic             dp_ovf;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign mag_a = abs_val(operand_a);
    assign mag_b = abs_val(operand_b);
    assign dp_op = (state == IDLE) ? (start_mult ? OP_MULT : OP_DIV) : op_q;

`ifdef MD_DIVIDE_EN
    assign div_reject = (operand_b == '0);
`else
    assign div_reject = 1'b1;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, stall and datapath sequencing; multiply wins when both starts arrive together
    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        dp_load     = 1'b0;
        dp_step     = 1'b0;
        finish_zero = 1'b0;
        case (state)
            IDLE: begin
                if (start_mult || start_div) begin
                    stall = 1'b1;
                    if (!start_mult && div_reject) begin
                        finish_zero = 1'b1;
                        state_next  = DONE;
                    end else begin
                        dp_load    = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall   = 1'b1;
                dp_step = 1'b1;
                if (count == '0) state_next = DONE;
            end
            DONE: begin
                stall = ~result_ack;
                if (result_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operation context: iteration count, op, result sign and destination register
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            op_q       <= OP_MULT;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            result_reg <= '0;
        end else if (dp_load) begin
            count      <= CW'(WIDTH - 1);
            op_q       <= dp_op;
            neg_q      <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            zero_q     <= 1'b0;
            result_reg <= dest_reg;
        end else if (finish_zero) begin
            op_q       <= OP_DIV;
            neg_q      <= 1'b0;
            zero_q     <= 1'b1;
            result_reg <= dest_reg;
        end else if (dp_step && count != '0) begin
            count      <= count - CW'(1);
        end
    end

    md_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .load      (dp_load),
        .step      (dp_step),
        .op        (dp_op),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .negative  (neg_q),
        .magnitude (dp_mag),
        .overflow  (dp_ovf)
    );

    // Datapath registers are frozen outside BUSY, so the corrected result is stable in DONE
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result       = zero_q ? '0 : (neg_q ? -dp_mag : dp_mag);
    assign exception    = zero_q | ((op_q == OP_MULT) & dp_ovf);

endmodule
